// File: rtl/panda_hazard_unit_if.sv
// Hazard-control bundle between the Panda pipeline and its hazard unit.
// master = pipeline side (drives hazard sources), slave = hazard unit.
interface panda_hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rs1_read_i;
  logic             id_rs2_read_i;
  logic [4:0]       id_ex_rd_addr_i;
  logic             id_ex_mem_read_i;
  logic             ex_branch_taken_i;
  logic             mem_req_i;
  logic             mem_done_i;
  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_stall_o;
  logic             id_ex_flush_o;
  logic             ex_mem_stall_o;
  logic             mem_wb_flush_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_count_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_rs1_read_i, id_rs2_read_i,
    output id_ex_rd_addr_i, id_ex_mem_read_i, ex_branch_taken_i,
    output mem_req_i, mem_done_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
    input  id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, mem_err_o,
    input  stall_count_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_read_i, id_rs2_read_i,
    input  id_ex_rd_addr_i, id_ex_mem_read_i, ex_branch_taken_i,
    input  mem_req_i, mem_done_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
    output id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, mem_err_o,
    output stall_count_o
  );
endinterface

// File: rtl/panda_hazard_unit.sv
// Panda pipeline hazard controller: load-use stalls, taken-branch flushes,
// data-memory wait/timeout FSM and a saturating stall-cycle counter.
module panda_hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  panda_hazard_unit_if.slave  hz
);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_flush;
  logic ex_mem_stall;
  logic mem_wb_flush;
  logic mem_err;

  // Memory-wait FSM next state; wait_cnt counts stalled cycles of the access
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hz.mem_req_i && !hz.mem_done_i) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (hz.mem_done_i) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d    = ST_ERR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Hazard detection
  always_comb begin
    mem_stall = ((state_q == ST_IDLE) && hz.mem_req_i && !hz.mem_done_i) ||
                ((state_q == ST_WAIT) && !hz.mem_done_i);
    rs1_hit   = hz.id_rs1_read_i && (hz.id_rs1_addr_i == hz.id_ex_rd_addr_i);
    rs2_hit   = hz.id_rs2_read_i && (hz.id_rs2_addr_i == hz.id_ex_rd_addr_i);
    load_use  = hz.id_ex_mem_read_i && (hz.id_ex_rd_addr_i != 5'd0) &&
                (rs1_hit || rs2_hit);
  end

  // Priority: memory stall, then branch flush, then load-use; all gated by reset
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    mem_err      = 1'b0;
    if (rst_ni) begin
      mem_err = (state_q == ST_ERR);
      if (mem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (hz.ex_branch_taken_i) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Saturating count of PC-stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_stall_o     = pc_stall;
  assign hz.if_id_stall_o  = if_id_stall;
  assign hz.if_id_flush_o  = if_id_flush;
  assign hz.id_ex_stall_o  = id_ex_stall;
  assign hz.id_ex_flush_o  = id_ex_flush;
  assign hz.ex_mem_stall_o = ex_mem_stall;
  assign hz.mem_wb_flush_o = mem_wb_flush;
  assign hz.mem_err_o      = mem_err;
  assign hz.stall_count_o  = stall_cnt_q;
endmodule

// File: tb/tb_panda_hazard_unit.sv
// Directed self-checking bench for panda_hazard_unit (MEM_TIMEOUT=4, CNT_W=4).
module tb_panda_hazard_unit;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;

  // Output vector order: pc, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_stall, mem_wb_flush, mem_err
  localparam logic [7:0] O_NONE   = 8'b0000_0000;
  localparam logic [7:0] O_MEM    = 8'b1101_0110;
  localparam logic [7:0] O_BRANCH = 8'b0010_1000;
  localparam logic [7:0] O_LOADU  = 8'b1100_1000;
  localparam logic [7:0] O_ERR    = 8'b0000_0001;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  panda_hazard_unit_if #(.CNT_W(CNT_W)) hz ();

  panda_hazard_unit #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] outs;
  assign outs = {hz.pc_stall_o, hz.if_id_stall_o, hz.if_id_flush_o, hz.id_ex_stall_o,
                 hz.id_ex_flush_o, hz.ex_mem_stall_o, hz.mem_wb_flush_o, hz.mem_err_o};

  task automatic clear_inputs();
    hz.id_rs1_addr_i     = 5'd0;
    hz.id_rs2_addr_i     = 5'd0;
    hz.id_rs1_read_i     = 1'b0;
    hz.id_rs2_read_i     = 1'b0;
    hz.id_ex_rd_addr_i   = 5'd0;
    hz.id_ex_mem_read_i  = 1'b0;
    hz.ex_branch_taken_i = 1'b0;
    hz.mem_req_i         = 1'b0;
    hz.mem_done_i        = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs are then applied
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_load_use();
    hz.id_ex_mem_read_i = 1'b1;
    hz.id_ex_rd_addr_i  = 5'd5;
    hz.id_rs1_addr_i    = 5'd5;
    hz.id_rs1_read_i    = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    hz.mem_req_i = 1'b1;
    settle();
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL reset_outs got=%b exp=%b", outs, O_NONE); bad++;
    end
    total++;
    if (hz.stall_count_o !== 4'd0) begin
      $display("FAIL reset_count got=%0d exp=0", hz.stall_count_o); bad++;
    end
    cyc();
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    cyc(); clear_inputs(); set_load_use(); settle();
    total++;
    if (outs !== O_LOADU) begin
      $display("FAIL load_use_rs1 got=%b exp=%b", outs, O_LOADU); bad++;
    end
    cyc(); clear_inputs(); set_load_use();
    hz.id_rs1_read_i = 1'b0; hz.id_rs2_read_i = 1'b1; hz.id_rs2_addr_i = 5'd5; settle();
    total++;
    if (outs !== O_LOADU) begin
      $display("FAIL load_use_rs2 got=%b exp=%b", outs, O_LOADU); bad++;
    end
    cyc(); clear_inputs(); set_load_use(); hz.id_ex_rd_addr_i = 5'd0; hz.id_rs1_addr_i = 5'd0; settle();
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL load_use_rd0 got=%b exp=%b", outs, O_NONE); bad++;
    end
    cyc(); clear_inputs(); set_load_use(); hz.id_rs1_read_i = 1'b0; settle();
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL load_use_noread got=%b exp=%b", outs, O_NONE); bad++;
    end
    cyc(); clear_inputs(); set_load_use(); hz.id_ex_mem_read_i = 1'b0; settle();
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL load_use_noload got=%b exp=%b", outs, O_NONE); bad++;
    end
  endtask

  task automatic test_branch_priority();
    cyc(); clear_inputs(); set_load_use(); hz.ex_branch_taken_i = 1'b1; settle();
    total++;
    if (outs !== O_BRANCH) begin
      $display("FAIL branch_over_load got=%b exp=%b", outs, O_BRANCH); bad++;
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      hz.mem_req_i  = 1'b1;
      hz.mem_done_i = (c == 3);
      settle();
      total++;
      if (outs !== ((c == 3) ? O_BRANCH & 8'h00 : O_MEM)) begin
        $display("FAIL mem_wait_c%0d got=%b exp=%b", c, outs, (c == 3) ? O_NONE : O_MEM); bad++;
      end
    end
    cyc(); clear_inputs(); settle();
    total++;
    if (hz.stall_count_o !== 4'd3) begin
      $display("FAIL mem_wait_count got=%0d exp=3", hz.stall_count_o); bad++;
    end
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL mem_wait_idle got=%b exp=%b", outs, O_NONE); bad++;
    end
    // done together with a fresh request: no stall, FSM stays idle
    cyc(); hz.mem_req_i = 1'b1; hz.mem_done_i = 1'b1; settle();
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL mem_same_cycle got=%b exp=%b", outs, O_NONE); bad++;
    end
    cyc(); clear_inputs(); settle();
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL mem_same_cycle_next got=%b exp=%b", outs, O_NONE); bad++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) cyc();
      hz.mem_req_i = (c <= 5);
      settle();
      total++;
      if (outs !== ((c <= 4) ? O_MEM : (c == 5) ? O_ERR : O_NONE)) begin
        $display("FAIL timeout_c%0d got=%b exp=%b", c, outs,
                 (c <= 4) ? O_MEM : (c == 5) ? O_ERR : O_NONE); bad++;
      end
    end
  endtask

  task automatic test_branch_in_wait();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      hz.mem_req_i = 1'b1; hz.ex_branch_taken_i = 1'b1; hz.mem_done_i = (c == 2);
      settle();
      total++;
      if (outs !== ((c == 2) ? O_BRANCH : O_MEM)) begin
        $display("FAIL branch_wait_c%0d got=%b exp=%b", c, outs, (c == 2) ? O_BRANCH : O_MEM); bad++;
      end
    end
    cyc(); clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hz.mem_req_i = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL rst_mid_outs got=%b exp=%b", outs, O_NONE); bad++;
    end
    total++;
    if (hz.stall_count_o !== 4'd0) begin
      $display("FAIL rst_mid_count got=%0d exp=0", hz.stall_count_o); bad++;
    end
    cyc();
    rst_n = 1'b1;
    hz.mem_req_i = 1'b0;
    settle();
    total++;
    if (outs !== O_NONE) begin
      $display("FAIL rst_mid_idle got=%b exp=%b", outs, O_NONE); bad++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (c == 14) begin
        settle();
        total++;
        if (hz.stall_count_o !== 4'd15) begin
          $display("FAIL sat_at15 got=%0d exp=15", hz.stall_count_o); bad++;
        end
      end
    end
    clear_inputs();
    cyc();
    settle();
    total++;
    if (hz.stall_count_o !== 4'd15) begin
      $display("FAIL sat_final got=%0d exp=15", hz.stall_count_o); bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_branch_in_wait();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/panda_hazard_unit.md
# panda_hazard_unit

Pipeline hazard controller for the Panda core. Sits beside the ID/EX/MEM pipeline registers, upstream of the EX-stage forwarding logic. Handles the hazards that forwarding cannot resolve:
- load-use stalls;
- taken-branch flushes;
- multi-cycle data-memory waits, with a timeout FSM.

It also counts pipeline stall cycles for performance monitoring.

## Interface
Parameters:
- MEM_TIMEOUT, 16, max memory-wait cycles after the first stalled cycle before abort (>=1)
- CNT_W, 32, stall counter width

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- id_rs1_addr_i  in  5  rs1 of instruction in ID
- id_rs2_addr_i  in  5  rs2 of instruction in ID
- id_rs1_read_i  in  1  ID instruction actually reads rs1
- id_rs2_read_i  in  1  ID instruction actually reads rs2
- id_ex_rd_addr_i  in  5  rd of instruction in EX
- id_ex_mem_read_i  in  1  instruction in EX is a load
- ex_branch_taken_i  in  1  branch/jump resolved taken in EX
- mem_req_i  in  1  MEM stage has a data-memory access this cycle
- mem_done_i  in  1  data memory completes the access this cycle
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF/ID register
- if_id_flush_o  out  1  clear IF/ID to bubble
- id_ex_stall_o  out  1  hold ID/EX register
- id_ex_flush_o  out  1  clear ID/EX to bubble
- ex_mem_stall_o  out  1  hold EX/MEM register
- mem_wb_flush_o  out  1  insert bubble into MEM/WB
- mem_err_o  out  1  one-cycle pulse: memory access timed out
- stall_count_o  out  CNT_W  cycles with pc_stall_o=1, saturating

## Operation
FSM states and transitions:
- IDLE → WAIT when mem_req_i=1 and mem_done_i=0. Load wait_cnt with 1.
- WAIT → IDLE when mem_done_i=1.
- WAIT → ERR when mem_done_i=0 and wait_cnt==MEM_TIMEOUT. Otherwise increment wait_cnt.
- ERR → IDLE unconditionally. mem_req_i is ignored in ERR.
- wait_cnt width is $clog2(MEM_TIMEOUT+1).

Memory stall (mem_stall):
- mem_stall = (IDLE & mem_req_i & ~mem_done_i) | (WAIT & ~mem_done_i).
- When asserted: pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o and mem_wb_flush_o are all 1.
- if_id_flush_o and id_ex_flush_o are forced to 0.
- mem_stall has the highest priority.

Branch flush:
- Applies when ex_branch_taken_i=1 and mem_stall=0.
- if_id_flush_o=1 and id_ex_flush_o=1, with no stalls asserted.
- A branch held in EX during a memory stall keeps ex_branch_taken_i high and takes effect in the first unstalled cycle.

Load-use stall:
- hazard = id_ex_mem_read_i & (id_ex_rd_addr_i!=0) & ((id_rs1_read_i & id_rs1_addr_i==id_ex_rd_addr_i) | (id_rs2_read_i & id_rs2_addr_i==id_ex_rd_addr_i)).
- Applies only when mem_stall=0 and ex_branch_taken_i=0.
- pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1. All other outputs are 0.

ERR state:
- mem_err_o=1.
- mem_stall=0, so branch and load-use logic are evaluated normally.

Stall counter:
- stall_count_o increments every cycle pc_stall_o=1.
- Saturates at all-ones.

## Timing
- Reset (rst_ni=0, asynchronous):
  - FSM goes to IDLE; wait_cnt=0; stall_count_o=0.
  - All other outputs are forced to 0 for the whole time rst_ni is low, including mid-WAIT.
- All control outputs are combinational from inputs and state, with zero latency. Stalls take effect in the same cycle the condition appears.
- Memory wait that completes:
  - The request is first seen in cycle 0 (stalled).
  - If mem_done_i arrives in cycle k, cycle k is unstalled and the pipeline advances.
- Memory wait that times out:
  - Cycles 0..MEM_TIMEOUT are stalled, i.e. MEM_TIMEOUT+1 stalled cycles.
  - Cycle MEM_TIMEOUT+1 is ERR: mem_err_o=1, no memory stall.
- mem_done_i in the same cycle as a new mem_req_i causes no stall and the FSM stays in IDLE.
- stall_count_o updates on the clock edge following each stalled cycle.

## Test plan
- Load-use: id_ex_mem_read_i=1, id_ex_rd_addr_i=5, id_rs1_addr_i=5, id_rs1_read_i=1 → pc_stall_o=if_id_stall_o=id_ex_flush_o=1 for that cycle. With id_ex_rd_addr_i=0, or with id_rs1_read_i=0 → all outputs 0.
- Branch beats load-use: same load-use inputs plus ex_branch_taken_i=1 → if_id_flush_o=id_ex_flush_o=1, pc_stall_o=0.
- Memory wait: mem_req_i=1 held, mem_done_i=1 in cycle 3 → four stalled outputs plus mem_wb_flush_o high in cycles 0-2, low in cycle 3; stall_count_o=3 afterwards.
- Timeout with MEM_TIMEOUT=4: mem_req_i held, mem_done_i never asserted → stalled in cycles 0-4; cycle 5 has mem_err_o=1 and stalls 0; cycle 6 returns to IDLE.
- Branch during memory wait: ex_branch_taken_i=1 while in WAIT → no flush; on the mem_done_i cycle if_id_flush_o=id_ex_flush_o=1.
- Reset mid-WAIT, then counter saturation:
  - Assert rst_ni=0 in cycle 2 of a wait → all outputs 0 immediately and stall_count_o=0; FSM in IDLE after release.
  - With CNT_W=4, 20 stalled cycles → stall_count_o=15.
